control_unit: RTL and testbench

- Main decoder of the RV32I core. It translates the 7-bit instruction opcode into datapath control strobes, ALU operand selects and an ALU-op class for the ALU decoder.
- A small run-state FSM gates decoding. It reports end-of-program (SYSTEM opcode) and illegal opcodes.
- Sits between instruction fetch/decode and the datapath. Enum types alu_sel_t and aluOp_t live in package definitions.

---
 rtl/control_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// RV32I main decoder: opcode to datapath control strobes.
// Run-state FSM gates decoding; flags program end and illegal opcodes.
package definitions;

  typedef enum logic [1:0] {
    REG   = 2'b00,
    PC    = 2'b01,
    IMM   = 2'b10,
    CONST = 2'b11
  } alu_sel_t;

  typedef enum logic [1:0] {
    ADD    = 2'b00,
    BRANCH = 2'b01,
    RTYPE  = 2'b10,
    ITYPE  = 2'b11
  } aluOp_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

module control_unit
  import definitions::*;
(
  input  logic       clk,
  input  logic       rstN,
  input  logic [6:0] opCode,
  input  logic       enable,
  input  logic       startProcess,
  output logic       endProcess,
  output logic       error,
  output logic       jump,
  output logic       jumpReg,
  output logic       branch,
  output logic       memRead,
  output logic       memWrite,
  output logic       memtoReg,
  output logic       regWrite,
  output alu_sel_t   aluSrc1,
  output alu_sel_t   aluSrc2,
  output aluOp_t     aluOp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  state_t state_q;
  logic   end_q;
  logic   err_q;

  logic   dec_en;
  logic   is_sys;
  logic   is_legal;

  logic     d_jump, d_jumpReg, d_branch;
  logic     d_memRead, d_memWrite;
  logic     d_memtoReg, d_regWrite;
  alu_sel_t d_src1, d_src2;
  aluOp_t   d_aluOp;

  assign dec_en = (state_q == S_RUN) && enable;

  // Raw opcode classification; X/Z never match so fall to illegal.
  always_comb begin
    is_sys     = 1'b0;
    is_legal   = 1'b0;
    d_jump     = 1'b0;
    d_jumpReg  = 1'b0;
    d_branch   = 1'b0;
    d_memRead  = 1'b0;
    d_memWrite = 1'b0;
    d_memtoReg = 1'b0;
    d_regWrite = 1'b0;
    d_src1     = REG;
    d_src2     = REG;
    d_aluOp    = ADD;
    case (opCode)
      OPC_LOAD: begin
        is_legal   = 1'b1;
        d_memRead  = 1'b1;
        d_memtoReg = 1'b1;
        d_regWrite = 1'b1;
        d_src2     = IMM;
      end
      OPC_OPIMM: begin
        is_legal   = 1'b1;
        d_regWrite = 1'b1;
        d_src2     = IMM;
        d_aluOp    = ITYPE;
      end
      OPC_AUIPC: begin
        is_legal   = 1'b1;
        d_regWrite = 1'b1;
        d_src1     = PC;
        d_src2     = IMM;
      end
      OPC_STORE: begin
        is_legal   = 1'b1;
        d_memWrite = 1'b1;
        d_src2     = IMM;
      end
      OPC_OP: begin
        is_legal   = 1'b1;
        d_regWrite = 1'b1;
        d_aluOp    = RTYPE;
      end
      OPC_LUI: begin
        is_legal   = 1'b1;
        d_regWrite = 1'b1;
        d_src1     = CONST;
        d_src2     = IMM;
      end
      OPC_BRANCH: begin
        is_legal   = 1'b1;
        d_branch   = 1'b1;
        d_aluOp    = BRANCH;
      end
      OPC_JALR: begin
        is_legal   = 1'b1;
        d_jump     = 1'b1;
        d_jumpReg  = 1'b1;
        d_regWrite = 1'b1;
        d_src1     = PC;
        d_src2     = CONST;
      end
      OPC_JAL: begin
        is_legal   = 1'b1;
        d_jump     = 1'b1;
        d_regWrite = 1'b1;
        d_src1     = PC;
        d_src2     = CONST;
      end
      OPC_SYSTEM: begin
        is_legal   = 1'b1;
        is_sys     = 1'b1;
      end
      default: begin
        is_legal   = 1'b0;
      end
    endcase
  end

  // Gate decode: outside an enabled RUN cycle everything idles.
  always_comb begin
    jump     = 1'b0;
    jumpReg  = 1'b0;
    branch   = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    memtoReg = 1'b0;
    regWrite = 1'b0;
    aluSrc1  = REG;
    aluSrc2  = REG;
    aluOp    = ADD;
    if (dec_en) begin
      jump     = d_jump;
      jumpReg  = d_jumpReg;
      branch   = d_branch;
      memRead  = d_memRead;
      memWrite = d_memWrite;
      memtoReg = d_memtoReg;
      regWrite = d_regWrite;
      aluSrc1  = d_src1;
      aluSrc2  = d_src2;
      aluOp    = d_aluOp;
    end
  end

  // Run-state FSM with registered end/error flags.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (startProcess) state_q <= S_RUN;
        end
        S_RUN: begin
          if (enable) begin
            if (is_sys) begin
              state_q <= S_DONE;
              end_q   <= 1'b1;
            end else if (!is_legal) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (startProcess) begin
            state_q <= S_RUN;
            end_q   <= 1'b0;
          end
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_IDLE;
          end_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign endProcess = end_q;
  assign error      = err_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit.
// Decode table vectors plus FSM corner sequences.
module tb_control_unit;

  logic       clk;
  logic       rstN;
  logic [6:0] opCode;
  logic       enable;
  logic       startProcess;
  logic       endProcess;
  logic       error;
  logic       jump, jumpReg, branch;
  logic       memRead, memWrite;
  logic       memtoReg, regWrite;
  logic [1:0] aluSrc1, aluSrc2, aluOp;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk          (clk),
    .rstN         (rstN),
    .opCode       (opCode),
    .enable       (enable),
    .startProcess (startProcess),
    .endProcess   (endProcess),
    .error        (error),
    .jump         (jump),
    .jumpReg      (jumpReg),
    .branch       (branch),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memtoReg     (memtoReg),
    .regWrite     (regWrite),
    .aluSrc1      (aluSrc1),
    .aluSrc2      (aluSrc2),
    .aluOp        (aluOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {jump,jumpReg,branch,memRead,memWrite,memtoReg,regWrite,src1,src2,op}
  function automatic logic [12:0] outs();
    return {jump, jumpReg, branch, memRead, memWrite,
            memtoReg, regWrite, aluSrc1, aluSrc2, aluOp};
  endfunction

  localparam logic [12:0] IDLE_OUT = 13'b0;

  task automatic chk(input string nm,
                     input logic [12:0] got,
                     input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic got,
                      input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic        en;
    logic [6:0]  op;
    logic [6:0]  stb;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [1:0]  ao;
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{"branch", 1'b1, 7'b1100011, 7'b0010000, 2'b00, 2'b00, 2'b01};
    vt[1]  = '{"jal",    1'b1, 7'b1101111, 7'b1000001, 2'b01, 2'b11, 2'b00};
    vt[2]  = '{"opimm",  1'b1, 7'b0010011, 7'b0000001, 2'b00, 2'b10, 2'b11};
    vt[3]  = '{"load",   1'b1, 7'b0000011, 7'b0001011, 2'b00, 2'b10, 2'b00};
    vt[4]  = '{"store",  1'b1, 7'b0100011, 7'b0000100, 2'b00, 2'b10, 2'b00};
    vt[5]  = '{"auipc",  1'b1, 7'b0010111, 7'b0000001, 2'b01, 2'b10, 2'b00};
    vt[6]  = '{"lui",    1'b1, 7'b0110111, 7'b0000001, 2'b11, 2'b10, 2'b00};
    vt[7]  = '{"op",     1'b1, 7'b0110011, 7'b0000001, 2'b00, 2'b00, 2'b10};
    vt[8]  = '{"jalr",   1'b1, 7'b1100111, 7'b1100001, 2'b01, 2'b11, 2'b00};
    vt[9]  = '{"bub_bad",1'b0, 7'b1111111, 7'b0000000, 2'b00, 2'b00, 2'b00};
    vt[10] = '{"bub_op", 1'b0, 7'b0110011, 7'b0000000, 2'b00, 2'b00, 2'b00};

    rstN = 1'b0;
    opCode = 7'b0;
    enable = 1'b0;
    startProcess = 1'b0;
    #12;
    chk("rst_outs", outs(), IDLE_OUT);
    chk1("rst_end", endProcess, 1'b0);
    chk1("rst_err", error, 1'b0);

    // Start with a bubble: IDLE decodes nothing.
    @(negedge clk);
    rstN = 1'b1;
    startProcess = 1'b1;
    enable = 1'b0;
    opCode = 7'b1100011;
    #1 chk("idle_outs", outs(), IDLE_OUT);
    @(posedge clk);
    @(negedge clk);
    startProcess = 1'b0;
    #1 chk("run_bubble", outs(), IDLE_OUT);

    // Table sweep in RUN.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      enable = vt[i].en;
      opCode = vt[i].op;
      #1 chk(vt[i].nm, outs(),
             {vt[i].stb, vt[i].s1, vt[i].s2, vt[i].ao});
    end
    @(negedge clk);
    enable = 1'b0;
    #1 chk1("no_err_bubble", error, 1'b0);
    chk1("no_end_sweep", endProcess, 1'b0);

    // SYSTEM ends the program; restart resumes decoding.
    @(negedge clk);
    enable = 1'b1;
    opCode = 7'b1110011;
    #1 chk("sys_outs", outs(), IDLE_OUT);
    chk1("sys_end_same", endProcess, 1'b0);
    @(negedge clk);
    opCode = 7'b0110011;
    #1 chk1("done_end", endProcess, 1'b1);
    chk("done_outs", outs(), IDLE_OUT);
    startProcess = 1'b1;
    @(negedge clk);
    startProcess = 1'b0;
    #1 chk1("restart_end", endProcess, 1'b0);
    chk("restart_op", outs(), 13'b0000001_00_00_10);

    // Illegal opcode: sticky error, startProcess ignored.
    @(negedge clk);
    opCode = 7'b1111111;
    #1 chk("ill_outs", outs(), IDLE_OUT);
    chk1("ill_err_same", error, 1'b0);
    @(negedge clk);
    opCode = 7'b0110011;
    startProcess = 1'b1;
    #1 chk1("ill_err", error, 1'b1);
    chk("err_outs", outs(), IDLE_OUT);
    repeat (2) @(negedge clk);
    startProcess = 1'b0;
    #1 chk1("err_sticky", error, 1'b1);
    chk("err_sticky_outs", outs(), IDLE_OUT);
    #2 rstN = 1'b0;
    #1 chk1("err_async_clr", error, 1'b0);

    // X opcode is illegal too.
    @(negedge clk);
    rstN = 1'b1;
    startProcess = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    startProcess = 1'b0;
    enable = 1'b1;
    opCode = 7'bxxxxxxx;
    #1 chk("x_outs", outs(), IDLE_OUT);
    @(negedge clk);
    #1 chk1("x_err", error, 1'b1);

    // Async reset mid-RUN zeroes decode immediately.
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    startProcess = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    startProcess = 1'b0;
    enable = 1'b1;
    opCode = 7'b1101111;
    #1 chk("jal_again", outs(), 13'b1000001_01_11_00);
    #1 rstN = 1'b0;
    #1 chk("async_rst_outs", outs(), IDLE_OUT);
    chk1("async_rst_end", endProcess, 1'b0);
    @(negedge clk);
    #1 chk("held_rst_outs", outs(), IDLE_OUT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
